// File: rtl/sat_pkg.sv
// rtl/sat_pkg.sv - shared types for the BCP conflict detector and its assignment table
package sat_pkg;

  localparam int VAR_IDX_W = 9;
  localparam int LEVEL_W   = 9;

  typedef logic [VAR_IDX_W-1:0] var_idx_t;
  typedef logic [LEVEL_W-1:0]   level_t;

  typedef struct packed {
    logic   valid;
    logic   val;
    level_t level;
  } assign_entry_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    CONFLICT = 2'd1,
    SWEEP    = 2'd2
  } cd_state_e;

endpackage

// File: rtl/var_assign_table.sv
// rtl/var_assign_table.sv - variable assignment table with multi-port write/read and a group-wise sweep-clear engine
module var_assign_table
  import sat_pkg::*;
#(
  parameter int NUM_VARS        = 512,
  parameter int LANES           = 2,
  parameter int SWEEP_PER_CYCLE = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  var_idx_t         rd_idx [LANES],
  output logic [LANES-1:0] rd_valid,
  output logic [LANES-1:0] rd_val,
  input  logic [LANES-1:0] wr_en,
  input  var_idx_t         wr_idx [LANES],
  input  assign_entry_t    wr_entry [LANES],
  input  logic             sweep_start,
  input  logic             sweep_clear_all,
  input  level_t           sweep_level,
  output logic             sweep_last
);

  localparam int NUM_GROUPS = NUM_VARS / SWEEP_PER_CYCLE;
  localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);

  logic [NUM_VARS-1:0] valid_q;
  logic                val_q   [NUM_VARS];
  level_t              level_q [NUM_VARS];

  logic             busy_q;
  logic             clr_all_q;
  level_t           lvl_q;
  logic [GRP_W-1:0] grp_q;
  var_idx_t         sw_idx [SWEEP_PER_CYCLE];

  for (genvar g = 0; g < LANES; g++) begin : g_rd
    assign rd_valid[g] = valid_q[rd_idx[g]];
    assign rd_val[g]   = val_q[rd_idx[g]];
  end

  for (genvar g = 0; g < SWEEP_PER_CYCLE; g++) begin : g_sw
    assign sw_idx[g] = var_idx_t'(int'(grp_q) * SWEEP_PER_CYCLE + g);
  end

  assign sweep_last = busy_q && en && (grp_q == LAST_GRP);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q    <= 1'b0;
      clr_all_q <= 1'b0;
      lvl_q     <= '0;
      grp_q     <= '0;
    end else if (sweep_start) begin
      busy_q    <= 1'b1;
      clr_all_q <= sweep_clear_all;
      lvl_q     <= sweep_level;
      grp_q     <= '0;
    end else if (busy_q && en) begin
      grp_q <= grp_q + 1'b1;
      if (grp_q == LAST_GRP) busy_q <= 1'b0;
    end
  end

  // Sweep and lane writes never overlap: writes only happen in RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      if (busy_q && en) begin
        for (int j = 0; j < SWEEP_PER_CYCLE; j++) begin
          if (clr_all_q || (level_q[sw_idx[j]] > lvl_q)) valid_q[sw_idx[j]] <= 1'b0;
        end
      end
      for (int k = 0; k < LANES; k++) begin
        if (wr_en[k]) valid_q[wr_idx[k]] <= wr_entry[k].valid;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < LANES; k++) begin
      if (wr_en[k]) begin
        val_q[wr_idx[k]]   <= wr_entry[k].val;
        level_q[wr_idx[k]] <= wr_entry[k].level;
      end
    end
  end

endmodule

// File: rtl/conflict_detector_mc.sv
// rtl/conflict_detector_mc.sv - multi-lane BCP conflict detector; CONFLICT_DETECTOR_STATS_EN adds conflict/duplicate counters
module conflict_detector_mc #(
  parameter int VAR_IDX_W       = sat_pkg::VAR_IDX_W,
  parameter int NUM_VARS        = 512,
  parameter int LANES           = 2,
  parameter int LEVEL_W         = sat_pkg::LEVEL_W,
  parameter int SWEEP_PER_CYCLE = 4,
  localparam int LANE_W         = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic [LANES-1:0]           in_valid,
  input  logic [LANES*VAR_IDX_W-1:0] var_idx_in,
  input  logic [LANES-1:0]           val_in,
  input  logic [LEVEL_W-1:0]         level_in,
  input  logic                       backtrack_req,
  input  logic [LEVEL_W-1:0]         backtrack_level,
  input  logic                       clear_req,
  output logic                       ready,
  output logic                       conflict,
  output logic [VAR_IDX_W-1:0]       conflict_var,
  output logic [LANE_W-1:0]          conflict_lane,
  output logic [LANES*VAR_IDX_W-1:0] var_idx_out,
  output logic [LANES-1:0]           val_out,
  output logic [LANES-1:0]           imply_stack_push_en
`ifdef CONFLICT_DETECTOR_STATS_EN
  ,
  output logic [15:0]                conflict_count,
  output logic [15:0]                dup_count
`endif
);

  import sat_pkg::*;

  localparam logic [VAR_IDX_W:0] NUM_VARS_L = (VAR_IDX_W + 1)'(NUM_VARS);

  cd_state_e state_q, state_d;

  logic                 req_take;
  logic                 accept;
  logic                 hit;
  logic [LANE_W-1:0]    hit_lane;
  logic [VAR_IDX_W-1:0] hit_var;
  logic [LANES-1:0]     wr_en;
  logic [LANES-1:0]     rd_valid;
  logic [LANES-1:0]     rd_val;
  logic                 sweep_last;
  logic [VAR_IDX_W-1:0] lane_idx [LANES];
  assign_entry_t        wr_entry [LANES];
`ifdef CONFLICT_DETECTOR_STATS_EN
  logic [LANES-1:0]     dup;
`endif

  // A taken request discards every implication presented in the same cycle.
  assign req_take = en && (state_q != SWEEP) && (backtrack_req || clear_req);
  assign accept   = en && (state_q == RUN) && !req_take;
  assign ready    = (state_q == RUN);
  assign conflict = (state_q == CONFLICT);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_idx[g] = var_idx_in[g*VAR_IDX_W +: VAR_IDX_W];
    assign wr_entry[g] = assign_entry_t'{valid: 1'b1, val: val_in[g], level: level_in};
  end

  // Lower lanes win; a lane that matches an earlier lane's fresh write sees it as assigned.
  always_comb begin
    logic stop;
    logic have;
    logic have_val;
    stop     = 1'b0;
    have     = 1'b0;
    have_val = 1'b0;
    wr_en    = '0;
    hit      = 1'b0;
    hit_lane = '0;
    hit_var  = '0;
`ifdef CONFLICT_DETECTOR_STATS_EN
    dup      = '0;
`endif
    for (int k = 0; k < LANES; k++) begin
      if (accept && in_valid[k] && ({1'b0, lane_idx[k]} < NUM_VARS_L) && !stop) begin
        have     = rd_valid[k];
        have_val = rd_val[k];
        for (int j = 0; j < LANES; j++) begin
          if (j < k && wr_en[j] && (lane_idx[j] == lane_idx[k])) begin
            have     = 1'b1;
            have_val = val_in[j];
          end
        end
        if (!have) begin
          wr_en[k] = 1'b1;
        end else if (have_val != val_in[k]) begin
          stop     = 1'b1;
          hit      = 1'b1;
          hit_lane = k[LANE_W-1:0];
          hit_var  = lane_idx[k];
        end else begin
`ifdef CONFLICT_DETECTOR_STATS_EN
          dup[k] = 1'b1;
`endif
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:      if (req_take) state_d = SWEEP; else if (hit) state_d = CONFLICT;
      CONFLICT: if (req_take) state_d = SWEEP;
      SWEEP:    if (sweep_last) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q             <= RUN;
      imply_stack_push_en <= '0;
      var_idx_out         <= '0;
      val_out             <= '0;
      conflict_var        <= '0;
      conflict_lane       <= '0;
    end else begin
      state_q             <= state_d;
      imply_stack_push_en <= wr_en;
      val_out             <= val_in & wr_en;
      for (int k = 0; k < LANES; k++) begin
        var_idx_out[k*VAR_IDX_W +: VAR_IDX_W] <= wr_en[k] ? lane_idx[k] : '0;
      end
      if (hit) begin
        conflict_var  <= hit_var;
        conflict_lane <= hit_lane;
      end
    end
  end

  var_assign_table #(
    .NUM_VARS        (NUM_VARS),
    .LANES           (LANES),
    .SWEEP_PER_CYCLE (SWEEP_PER_CYCLE)
  ) u_table (
    .clock           (clock),
    .reset           (reset),
    .en              (en),
    .rd_idx          (lane_idx),
    .rd_valid        (rd_valid),
    .rd_val          (rd_val),
    .wr_en           (wr_en),
    .wr_idx          (lane_idx),
    .wr_entry        (wr_entry),
    .sweep_start     (req_take),
    .sweep_clear_all (clear_req),
    .sweep_level     (backtrack_level),
    .sweep_last      (sweep_last)
  );

`ifdef CONFLICT_DETECTOR_STATS_EN
  logic [15:0] dup_inc;
  logic [16:0] dup_sum;

  always_comb begin
    dup_inc = '0;
    for (int k = 0; k < LANES; k++) begin
      if (dup[k]) dup_inc = dup_inc + 16'd1;
    end
    dup_sum = {1'b0, dup_count} + {1'b0, dup_inc};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conflict_count <= '0;
      dup_count      <= '0;
    end else if (req_take && clear_req) begin
      conflict_count <= '0;
      dup_count      <= '0;
    end else begin
      if (hit && (conflict_count != 16'hFFFF)) conflict_count <= conflict_count + 16'd1;
      dup_count <= dup_sum[16] ? 16'hFFFF : dup_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_conflict_detector_mc.sv
// tb/tb_conflict_detector_mc.sv - randomized self-checking bench for conflict_detector_mc against a table-level model
module tb_conflict_detector_mc;

  localparam int VW  = 9;
  localparam int NV  = 512;
  localparam int L   = 2;
  localparam int SPC = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    in_valid = '0;
  logic [17:0]   var_idx_in = '0;
  logic [1:0]    val_in = '0;
  logic [8:0]    level_in = '0;
  logic          backtrack_req = 1'b0;
  logic [8:0]    backtrack_level = '0;
  logic          clear_req = 1'b0;
  logic          ready;
  logic          conflict;
  logic [8:0]    conflict_var;
  logic [0:0]    conflict_lane;
  logic [17:0]   var_idx_out;
  logic [1:0]    val_out;
  logic [1:0]    imply_stack_push_en;
`ifdef CONFLICT_DETECTOR_STATS_EN
  logic [15:0]   conflict_count;
  logic [15:0]   dup_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  conflict_detector_mc dut (
    .clock               (clock),
    .reset               (reset),
    .en                  (en),
    .in_valid            (in_valid),
    .var_idx_in          (var_idx_in),
    .val_in              (val_in),
    .level_in            (level_in),
    .backtrack_req       (backtrack_req),
    .backtrack_level     (backtrack_level),
    .clear_req           (clear_req),
    .ready               (ready),
    .conflict            (conflict),
    .conflict_var        (conflict_var),
    .conflict_lane       (conflict_lane),
    .var_idx_out         (var_idx_out),
    .val_out             (val_out),
    .imply_stack_push_en (imply_stack_push_en)
`ifdef CONFLICT_DETECTOR_STATS_EN
    ,
    .conflict_count      (conflict_count),
    .dup_count           (dup_count)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: 0 = accepting, 1 = stuck on conflict, 2 = sweeping for m_left cycles.
  bit       m_valid [NV];
  bit       m_val   [NV];
  int       m_level [NV];
  int       m_mode;
  int       m_left;
  int       m_cvar;
  int       m_clane;
  logic [1:0] e_push;
  logic [8:0] e_idx [2];
  logic [1:0] e_val;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) m_valid[v] = 1'b0;
    m_mode  = 0;
    m_left  = 0;
    m_cvar  = 0;
    m_clane = 0;
    e_push  = '0;
    e_idx[0] = '0;
    e_idx[1] = '0;
    e_val   = '0;
  endtask

  task automatic model_step();
    int idx;
    e_push = '0;
    e_idx[0] = '0;
    e_idx[1] = '0;
    e_val  = '0;
    if (m_mode == 2) begin
      if (en) begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    end else if (en && (clear_req || backtrack_req)) begin
      for (int v = 0; v < NV; v++) begin
        if (clear_req || (m_level[v] > int'(backtrack_level))) m_valid[v] = 1'b0;
      end
      m_mode = 2;
      m_left = NV / SPC;
    end else if (en && m_mode == 0) begin
      for (int k = 0; k < L; k++) begin
        if (!in_valid[k]) continue;
        idx = int'(var_idx_in[k*VW +: VW]);
        if (idx >= NV) continue;
        if (!m_valid[idx]) begin
          m_valid[idx] = 1'b1;
          m_val[idx]   = val_in[k];
          m_level[idx] = int'(level_in);
          e_push[k]    = 1'b1;
          e_idx[k]     = 9'(idx);
          e_val[k]     = val_in[k];
        end else if (m_val[idx] != val_in[k]) begin
          m_mode  = 1;
          m_cvar  = idx;
          m_clane = k;
          break;
        end
      end
    end
  endtask

  task automatic check_all();
    check("ready", ready, (m_mode == 0));
    check("conflict", conflict, (m_mode == 1));
    check("push_en", imply_stack_push_en, e_push);
    check("var_idx_out", var_idx_out, {e_idx[1], e_idx[0]});
    check("val_out", val_out, e_val);
    check("conflict_var", conflict_var, m_cvar);
    check("conflict_lane", conflict_lane, m_clane);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
  endtask

  task automatic drive(input logic e, input logic [1:0] v, input int i0, input bit b0,
                       input int i1, input bit b1, input int lvl, input bit bt,
                       input int btl, input bit clr);
    en              = e;
    in_valid        = v;
    var_idx_in      = {9'(i1), 9'(i0)};
    val_in          = {b1, b0};
    level_in        = 9'(lvl);
    backtrack_req   = bt;
    backtrack_level = 9'(btl);
    clear_req       = clr;
    cycle();
  endtask

  task automatic idle();
    drive(1'b1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic wait_sweep(output int n);
    n = 0;
    while (!ready && n < 300) begin
      idle();
      n++;
    end
    check("sweep_bound", ready, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    for (int v = 0; v < NV; v++) begin
      m_val[v]   = 1'b0;
      m_level[v] = 0;
    end
    repeat (2) @(negedge clock);
    check_all();
    reset = 1'b1;
    @(negedge clock);

    drive(1, 2'b11, 1, 0, 2, 1, 1, 0, 0, 0);
    check("tp_push_both", imply_stack_push_en, 2'b11);
    check("tp_idx_both", var_idx_out, {9'd2, 9'd1});
    drive(1, 2'b01, 1, 1, 0, 0, 1, 0, 0, 0);
    check("tp_conflict", conflict, 1'b1);
    check("tp_cvar", conflict_var, 9'd1);
    check("tp_ready_low", ready, 1'b0);
    drive(1, 2'b01, 5, 0, 0, 0, 1, 0, 0, 0);
    check("tp_ignored", imply_stack_push_en, 2'b00);
    drive(1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1);
    wait_sweep(n);

    drive(1, 2'b11, 7, 1, 7, 0, 1, 0, 0, 0);
    check("tp_same_var_push", imply_stack_push_en, 2'b01);
    check("tp_same_var_lane", conflict_lane, 1'b1);
    check("tp_same_var_cvar", conflict_var, 9'd7);
    drive(1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1);
    wait_sweep(n);

    drive(1, 2'b11, 8, 0, 8, 0, 1, 0, 0, 0);
    check("tp_dup_push", imply_stack_push_en, 2'b01);

    drive(1, 2'b01, 3, 1, 0, 0, 1, 0, 0, 0);
    drive(1, 2'b01, 4, 0, 0, 0, 3, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 0, 0, 3, 1, 2, 0);
    wait_sweep(n);
    check("bt_len", n, 128);
    drive(1, 2'b01, 4, 1, 0, 0, 1, 0, 0, 0);
    check("bt_reassign", imply_stack_push_en, 2'b01);
    drive(1, 2'b01, 3, 0, 0, 0, 1, 0, 0, 0);
    check("bt_kept_conflict", conflict, 1'b1);
    drive(1, 2'b00, 0, 0, 0, 0, 1, 0, 0, 1);
    wait_sweep(n);

    drive(1, 2'b01, 9, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 2'b01, 9, 1, 0, 0, 1, 0, 0, 0);
    check("en_off_conflict", conflict, 1'b0);
    check("en_off_push", imply_stack_push_en, 2'b00);
    drive(1, 2'b01, 511, 1, 511, 0, 2, 0, 0, 0);
    drive(1, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0);
    repeat (5) idle();
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_ready", ready, 1'b1);
    check_all();
    @(negedge clock);
    reset = 1'b1;
    drive(1, 2'b01, 9, 1, 0, 0, 1, 0, 0, 0);
    check("rst_table_clear", imply_stack_push_en, 2'b01);

    for (int t = 0; t < 3000; t++) begin
      drive($urandom_range(0, 9) != 0,
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0) ? 511 : int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0) ? 511 : int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)),
            $urandom_range(0, 59) == 0,
            int'($urandom_range(0, 7)),
            $urandom_range(0, 199) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conflict_detector_mc.md
Name: conflict_detector_mc

Overview:
- Multi-lane successor to the single-lane conflict detector in the SAT accelerator's BCP path.
- Each cycle, accepts up to LANES implied (variable, value) pairs from the clause evaluators and checks them against an internal variable assignment table, which also records decision levels.
- Flags conflicts and raises per-lane push enables toward the implication stack.
- Supports backtracking to a decision level by sweeping the table, and a full clear.

Parameters:
- VAR_IDX_W, 9: variable index width.
- NUM_VARS, 512: table depth; must be ≤ 2**VAR_IDX_W.
- LANES, 2: implications accepted per cycle.
- LEVEL_W, 9: decision-level width.
- SWEEP_PER_CYCLE, 4: table entries examined per backtrack cycle; must divide NUM_VARS.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  global enable; when 0, no table update and no outputs asserted.
- in_valid  in  LANES  per-lane implication valid.
- var_idx_in  in  LANES*VAR_IDX_W  per-lane variable; lane k occupies bits [k*VAR_IDX_W +: VAR_IDX_W].
- val_in  in  LANES  per-lane implied value.
- level_in  in  LEVEL_W  current decision level, stored with new assignments.
- backtrack_req  in  1  one-cycle pulse starting a backtrack.
- backtrack_level  in  LEVEL_W  entries with level > this value are unassigned.
- clear_req  in  1  unassign all entries; same sweep as backtrack with level treated as -1.
- ready  out  1  high in RUN; implications are accepted only when ready=1.
- conflict  out  1  sticky conflict flag.
- conflict_var  out  VAR_IDX_W  variable of the first conflict.
- conflict_lane  out  $clog2(LANES) (min 1)  lane that caused the first conflict.
- var_idx_out  out  LANES*VAR_IDX_W  registered copy of accepted variables.
- val_out  out  LANES  registered copy of accepted values.
- imply_stack_push_en  out  LANES  per-lane push strobe, one cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - All table valid bits cleared; state RUN.
  - All outputs 0, except ready=1.
- Latency: one cycle. Inputs sampled at posedge N; outputs valid after posedge N and held for exactly one cycle. conflict_* are the exception and are sticky.
- States: RUN, CONFLICT, SWEEP.
  - RUN → CONFLICT on a detected conflict.
  - RUN or CONFLICT → SWEEP on backtrack_req or clear_req.
  - SWEEP → RUN after the last entry group is processed: NUM_VARS/SWEEP_PER_CYCLE cycles, then ready=1 on the following cycle.
- Lane resolution in RUN (en=1), lanes in ascending priority (lane 0 first):
  - Unassigned variable, not claimed by a lower lane: write {valid, val, level_in}; push_en[k]=1.
  - Assigned with the same value, or claimed by a lower lane with the same value: duplicate; no push, no conflict.
  - Assigned, or claimed by a lower lane, with the opposite value: conflict; lane k records conflict_var/conflict_lane.
  - On a conflict at lane k: lanes below k commit and push; lane k and all higher lanes are dropped with no write and no push.
- CONFLICT state: ready=0; all implications ignored; conflict stays 1 until a sweep starts.
- SWEEP:
  - conflict cleared on entry.
  - Each cycle, examines SWEEP_PER_CYCLE consecutive entries from index 0 and clears valid where level > backtrack_level.
  - backtrack_level is latched at the request.
  - ready=0 throughout.
- Simultaneous events:
  - clear_req has priority over backtrack_req.
  - A request in the same cycle as a conflicting implication: the implication is discarded and the sweep starts.
  - Requests arriving during SWEEP are ignored.
- en=0: state and table hold; push_en=0; the sweep counter pauses.
- in_valid lanes with var_idx ≥ NUM_VARS are ignored: no push, no conflict.

Optional Feature:
- Macro: CONFLICT_DETECTOR_STATS_EN.
- Defined: adds outputs conflict_count[15:0] and dup_count[15:0].
  - conflict_count increments by 1 per detected conflict.
  - dup_count increments by the number of duplicate lanes per cycle.
  - Both saturate at 16'hFFFF and are zeroed by reset and clear_req, but not by backtrack_req.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package sat_pkg contains:
  - VAR_IDX_W and LEVEL_W defaults.
  - typedefs var_idx_t, level_t.
  - struct assign_entry_t {valid, val, level}.
  - enum cd_state_e {RUN, CONFLICT, SWEEP}.
- One sub-module, var_assign_table: storage, LANES write ports, LANES read ports, and the sweep-clear engine.
- Lane resolution and the FSM stay in conflict_detector_mc.

Test Plan:
- LANES=2, level_in=1: lane0 (1,0) and lane1 (2,1) → next cycle push_en=2'b11, var_idx_out={2,1}, conflict=0.
- Then lane0 (1,1) → conflict=1, conflict_var=1, conflict_lane=0, push_en=0, ready=0; a further input (5,0) is ignored.
- Same cycle, lane0 (7,1) and lane1 (7,0) → lane0 pushes, conflict_lane=1.
- Same cycle, lane0 (8,0) and lane1 (8,0) → push_en=2'b01 only.
- Assign (3,1)@level1 and (4,0)@level3, then backtrack_req with backtrack_level=2 → ready=0 for 128 cycles, then ready=1; (4,1) is accepted and (3,0) conflicts.
- en=0 with a conflicting input → conflict=0, push_en=0. Then reset low mid-SWEEP → table cleared, ready=1 after release.
